// File: rtl/result_pkg.sv
// Shared definitions for the result collector: FSM encoding, saturation
// bounds for the quantized lane width, and the row packing helper.
package result_pkg;

    localparam int Q_W     = 8;   // quantized lane width (signed)
    localparam int Q_ACC_W = 16;  // accumulator width (signed)
    localparam int Q_LANES = 4;   // lanes per packed row

    // Saturation window for a signed Q_W-bit result.
    localparam int QMAX = (1 << (Q_W - 1)) - 1;
    localparam int QMIN = -(1 << (Q_W - 1));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Lane 0 lands in the LSBs, the last lane in the MSBs.
    function automatic logic [Q_LANES*Q_W-1:0] pack_row(input logic [Q_W-1:0] lanes [Q_LANES]);
        logic [Q_LANES*Q_W-1:0] row;
        row = '0;
        for (int i = 0; i < Q_LANES; i++) begin
            row[i*Q_W +: Q_W] = lanes[i];
        end
        return row;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Per-lane requantizer: optional ReLU, arithmetic (floor) right shift,
// then saturation into the signed quantized range.
module requant_lane
    import result_pkg::*;
#(
    parameter int ACC_W = Q_ACC_W
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic                    relu_en_i,
    input  logic [3:0]              shift_i,
    output logic [Q_W-1:0]          q_o
);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(QMAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(QMIN);

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] y;

    // Clamp, shift and saturate; the shift keeps the sign so negatives floor.
    always_comb begin
        x = (relu_en_i && acc_i[ACC_W-1]) ? '0 : acc_i;
        y = x >>> shift_i;
        if (y > SAT_HI) begin
            q_o = SAT_HI[Q_W-1:0];
        end else if (y < SAT_LO) begin
            q_o = SAT_LO[Q_W-1:0];
        end else begin
            q_o = y[Q_W-1:0];
        end
    end

endmodule

// File: rtl/result_collector.sv
// Result collector: requantizes four MAC lanes, aligns skewed lane strobes
// into packed rows, buffers rows in a show-ahead FIFO and drains them over a
// valid/ready handshake, pulsing done once the whole layer has left.
module result_collector
    import result_pkg::*;
#(
    parameter int W          = Q_W,
    parameter int ACC_W      = Q_ACC_W,
    parameter int N_MACS     = Q_LANES,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear_all,
    input  logic [ROW_CNT_W-1:0]    rows_total,
    input  logic                    relu_en,
    input  logic [3:0]              shift,
    input  logic signed [ACC_W-1:0] acc_in_0,
    input  logic signed [ACC_W-1:0] acc_in_1,
    input  logic signed [ACC_W-1:0] acc_in_2,
    input  logic signed [ACC_W-1:0] acc_in_3,
    input  logic [N_MACS-1:0]       valid_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N_MACS*W-1:0]     res_data,
    output logic [ROW_CNT_W-1:0]    res_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic                    lane_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    // FSM and configuration
    state_e                 state_q, state_d;
    logic [ROW_CNT_W-1:0]   rows_total_q, rows_total_d;
    logic                   relu_q, relu_d;
    logic [3:0]             shift_q, shift_d;

    // Row counters: rows_done counts pushed plus dropped rows
    logic [ROW_CNT_W-1:0]   rows_done_q, rows_done_d;
    logic [ROW_CNT_W-1:0]   rows_popped_q, rows_popped_d;

    // Lane alignment
    logic signed [ACC_W-1:0] acc_arr [N_MACS];
    logic [W-1:0]           q_lane [N_MACS];
    logic [W-1:0]           lane_q [N_MACS];
    logic [N_MACS-1:0]      pending_q, pending_d;
    logic [N_MACS-1:0]      capture;

    // Row FIFO (pointers carry one extra wrap bit)
    logic [N_MACS*W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]            fifo_count;
    logic                   fifo_empty, fifo_full;

    // Status
    logic                   overflow_q, overflow_d;
    logic                   lane_err_q, lane_err_d;
    logic                   done_q, done_d;

    logic                   collecting, row_push, push_accept, row_drop, pop, err_hit;

    assign acc_arr[0] = acc_in_0;
    assign acc_arr[1] = acc_in_1;
    assign acc_arr[2] = acc_in_2;
    assign acc_arr[3] = acc_in_3;

    generate
        for (genvar gi = 0; gi < N_MACS; gi++) begin : g_lane
            requant_lane #(.ACC_W(ACC_W)) u_requant (
                .acc_i     (acc_arr[gi]),
                .relu_en_i (relu_q),
                .shift_i   (shift_q),
                .q_o       (q_lane[gi])
            );
        end
    endgenerate

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_FULL);

    assign collecting  = (state_q == COLLECT);
    assign capture     = collecting ? valid_in : '0;
    assign row_push    = collecting && (&pending_q);
    assign pop         = !fifo_empty && res_ready;
    // A full FIFO still takes a row when a pop frees a slot on the same edge.
    assign push_accept = row_push && (!fifo_full || pop);
    assign row_drop    = row_push && fifo_full && !pop;
    assign err_hit     = collecting && !row_push && (|(valid_in & pending_q));

    assign res_valid = !fifo_empty;
    assign res_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign res_addr  = rows_popped_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign lane_err  = lane_err_q;

    // Next-state logic for the FSM, counters, FIFO pointers and sticky flags.
    always_comb begin
        state_d       = state_q;
        rows_total_d  = rows_total_q;
        relu_d        = relu_q;
        shift_d       = shift_q;
        rows_done_d   = rows_done_q + ROW_CNT_W'(row_push);
        rows_popped_d = rows_popped_q + ROW_CNT_W'(pop);
        wr_ptr_d      = wr_ptr_q + (AW+1)'(push_accept);
        rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
        pending_d     = collecting ? ((pending_q & {N_MACS{~row_push}}) | valid_in) : pending_q;
        overflow_d    = overflow_q | row_drop;
        lane_err_d    = lane_err_q | err_hit;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_total_d  = rows_total;
                    relu_d        = relu_en;
                    shift_d       = shift;
                    rows_done_d   = '0;
                    rows_popped_d = '0;
                    pending_d     = '0;
                    overflow_d    = 1'b0;
                    lane_err_d    = 1'b0;
                    state_d       = (rows_total == '0) ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (rows_done_d == rows_total_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the last pop empties the FIFO.
                if (wr_ptr_d == rd_ptr_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over every transition, including a same-cycle start.
        if (clear_all) begin
            state_d       = IDLE;
            rows_done_d   = '0;
            rows_popped_d = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            pending_d     = '0;
            overflow_d    = 1'b0;
            lane_err_d    = 1'b0;
            done_d        = 1'b0;
        end
    end

    // Control, counter and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rows_total_q  <= '0;
            relu_q        <= 1'b0;
            shift_q       <= '0;
            rows_done_q   <= '0;
            rows_popped_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pending_q     <= '0;
            overflow_q    <= 1'b0;
            lane_err_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rows_total_q  <= rows_total_d;
            relu_q        <= relu_d;
            shift_q       <= shift_d;
            rows_done_q   <= rows_done_d;
            rows_popped_q <= rows_popped_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            lane_err_q    <= lane_err_d;
            done_q        <= done_d;
        end
    end

    // Lane holding registers: a strobe (re)loads the requantized value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MACS; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_MACS; i++) begin
                if (capture[i]) begin
                    lane_q[i] <= q_lane[i];
                end
            end
        end
    end

    // Row storage; read side is combinational so the head row is shown ahead.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= pack_row(lane_q);
        end
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream stage of the MAC array top level. It consumes acc_out_0..3 and the per-lane valid_out bits.
- Each lane is requantized (optional ReLU, arithmetic right shift, saturation to W bits). Lanes that arrive skewed are aligned into one packed row of N_MACS results.
- Rows are buffered in a small show-ahead FIFO and drained over a valid/ready handshake into the next layer's input memory writer.
- The block tracks a per-layer row count and pulses done when the layer has fully drained.

Parameters:
- W, 8, quantized result width per lane (signed).
- ACC_W, 16, accumulator input width (signed).
- N_MACS, 4, number of lanes; fixed at 4 because the ports are explicit.
- FIFO_DEPTH, 4, row FIFO depth; must be a power of two, at least 2.
- ROW_CNT_W, 8, width of the row counter and of rows_total.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a layer collection. Ignored unless in IDLE.
- clear_all  in  1  synchronous flush: FIFO emptied, pending cleared, counters zeroed, FSM to IDLE. No done pulse.
- rows_total  in  ROW_CNT_W  rows expected this layer; sampled on start.
- relu_en  in  1  clamp negative accumulators to 0 before the shift; sampled on start.
- shift  in  4  arithmetic right-shift amount, 0..15; sampled on start.
- acc_in_0..acc_in_3  in  ACC_W each  signed accumulators, from acc_out_0..3.
- valid_in  in  N_MACS  per-lane capture strobes, from valid_out.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  downstream accept.
- res_data  out  N_MACS*W  head row: lane0 in bits [W-1:0], lane3 in the MSBs.
- res_addr  out  ROW_CNT_W  row index of the head row.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when the layer completes.
- overflow  out  1  sticky; set when a completed row is dropped because the FIFO was full.
- lane_err  out  1  sticky; set when a lane strobes again while its pending bit is already set.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - FIFO is empty, pending=0, rows_pushed=0, rows_popped=0, FSM=IDLE.
  - Config registers are 0.
- FSM states are IDLE, COLLECT, DRAIN.
  - IDLE -> COLLECT on start: latch rows_total, relu_en and shift; zero the counters; clear overflow and lane_err.
  - If rows_total=0, go IDLE -> DRAIN instead; done pulses the next cycle.
  - COLLECT -> DRAIN on the cycle rows_pushed + overflow-dropped rows reaches rows_total.
  - DRAIN -> IDLE when the FIFO is empty. done=1 on that transition cycle.
  - clear_all overrides all transitions; it has priority over start in the same cycle.
- Lane capture applies in COLLECT only. valid_in is ignored in IDLE and DRAIN.
  - On valid_in[i] at edge t: lane_reg[i] <= requant(acc_in_i), pending[i] <= 1.
  - If pending[i] is already 1 and the row is not being pushed this cycle: overwrite the value and set lane_err.
- Requant, per lane, combinational:
  - x = (relu_en && acc<0) ? 0 : acc.
  - y = x >>> shift, arithmetic (floor).
  - Saturate y to [-2^(W-1), 2^(W-1)-1]; for W=8 that is [-128, 127].
- Row push:
  - When pending is all ones, the packed row is written to the FIFO at that edge and pending clears.
  - A valid_in arriving in the same cycle sets pending for the next row.
  - Latency: last lane strobe at edge t -> pending full after t -> FIFO write at edge t+1 -> res_valid=1 after t+1 (2 cycles).
- FIFO is show-ahead.
  - Pop occurs when res_valid && res_ready.
  - When full, a push in the same cycle as a pop is accepted.
  - A push when full with no pop drops the row, sets overflow, and still counts toward rows_total.
  - res_data and res_valid stay stable while res_valid && !res_ready.
- res_addr = rows_popped, which increments on each pop and wraps modulo 2^ROW_CNT_W.
- Partial pending at the DRAIN transition cannot occur; a strobe in DRAIN is ignored.
- A start in COLLECT or DRAIN is ignored.

Decomposition:
- Shared package (result_pkg):
  - FSM state encoding (IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2).
  - QMAX/QMIN localparams derived from W.
  - A row packing function.
- Sub-module requant_lane (acc, relu_en, shift -> q[W-1:0]), instantiated N_MACS times.
- The FIFO stays inline.

Test Plan:
- Aligned row: rows_total=1, shift=0, relu off, acc={5,-3,100,-100}, all valid_in in one cycle -> res_valid two cycles later, res_data lanes {5,-3,100,-100}, res_addr=0; pop -> done pulse next cycle, busy=0.
- Skewed lanes with saturation: shift=2, relu on; lanes strobed on cycles t..t+3 with acc {1000,-40,7,600} -> single row {127,0,1,127}, res_valid at t+5.
- Backpressure and overflow: FIFO_DEPTH=4, rows_total=6, res_ready=0 while 6 rows complete -> 4 rows buffered, overflow=1; then res_ready=1 -> 4 pops with res_addr 0..3, then done.
- Double strobe: valid_in[2] twice before the row completes, second acc=9 -> lane_err=1, lane2 of the row = 9.
- Mid-layer clear_all with 2 rows buffered and pending=4'b0011 -> next cycle res_valid=0, busy=0, no done; then start with rows_total=1 -> normal completion.
- Async reset asserted mid-DRAIN -> all outputs 0 immediately; start ignored while rst=0.
